// File: rtl/universal_ff_reg_pkg.sv
// Shared mode encoding for the universal flip-flop register bank.
package uff_pkg;

  typedef logic [1:0] uff_mode_t;

  localparam uff_mode_t MODE_SR = 2'b00;
  localparam uff_mode_t MODE_JK = 2'b01;
  localparam uff_mode_t MODE_D  = 2'b10;
  localparam uff_mode_t MODE_T  = 2'b11;

endpackage

// File: rtl/universal_ff_reg_next_state.sv
// One-bit next-state function for the universal flip-flop (SR/JK/D/T).
module uff_next_state
  import uff_pkg::*;
(
  input  logic      q,
  input  logic      a,
  input  logic      b,
  input  uff_mode_t mode,
  output logic      q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      // S=R=1 is treated as hold so the bit never goes X or oscillates
      MODE_SR: q_next = (a & ~b) ? 1'b1 : ((~a & b) ? 1'b0 : q);
      MODE_JK: q_next = (a & ~q) | (~b & q);
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_ff_reg.sv
// WIDTH-bit multi-mode (SR/JK/D/T) flip-flop bank with clock enable and illegal-SR flagging.
// Optional saturating illegal-SR event counter on err_cnt when UFF_ERR_CNT_EN is defined.
module universal_ff_reg
  import uff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic                 changed,
  output logic                 sr_err
`ifdef UFF_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic [WIDTH-1:0] q_next;
  logic             sr_err_now;

`ifdef UFF_ERR_CNT_EN
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    uff_next_state u_ns (
      .q      (q[i]),
      .a      (a[i]),
      .b      (b[i]),
      .mode   (mode),
      .q_next (q_next[i])
    );
  end

  assign sr_err_now = (mode == MODE_SR) && (|(a & b));
  assign qbar       = ~q;

  // Register stage: all state lives in this one block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
      sr_err  <= 1'b0;
`ifdef UFF_ERR_CNT_EN
      err_cnt <= '0;
`endif
    end else if (en) begin
      q       <= q_next;
      changed <= (q_next != q);
      sr_err  <= sr_err_now;
`ifdef UFF_ERR_CNT_EN
      if (sr_err_now) err_cnt <= sat_inc(err_cnt);
`endif
    end else begin
      changed <= 1'b0;
      sr_err  <= 1'b0;
    end
  end

endmodule
